// File: rtl/retire_trace_checker.sv
// Stores a trace of expected retirements (PC + result) and checks live retirements against it in order.
// Latency: verdict registers update one edge after each retirement; no backpressure on retire (load_ready gates trace writes in IDLE only).
module retire_trace_checker #(
    parameter int XLEN    = 32,
    parameter int DEPTH   = 64,
    parameter int TIMEOUT = 1000,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            load_valid,
    output logic            load_ready,
    input  logic [XLEN-1:0] load_pc,
    input  logic [XLEN-1:0] load_result,
    input  logic            start,
    input  logic            retire_valid,
    input  logic [XLEN-1:0] retire_pc,
    input  logic [XLEN-1:0] retire_result,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic            timeout,
    output logic [AW-1:0]   fail_idx,
    output logic [AW:0]     mismatch_cnt,
    output logic [31:0]     cycle_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [AW:0] FULL     = (AW+1)'(DEPTH);
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT - 1);

    state_t          state;
    state_t          state_nxt;
    logic [AW:0]     count;
    logic [AW:0]     ptr;
    logic [AW-1:0]   ptr_idx;
    logic [XLEN-1:0] trace_pc     [DEPTH];
    logic [XLEN-1:0] trace_result [DEPTH];
    logic            load_acc;
    logic            cmp_en;
    logic            cmp_hit;
    logic            last_cmp;
    logic            tmo_hit;

    assign ptr_idx    = ptr[AW-1:0];
    // Gated by reset so the port reads 0 while reset is asserted.
    assign load_ready = rst && (state == S_IDLE) && (count < FULL);
    assign busy       = (state == S_RUN);
    assign done       = (state == S_DONE);
    assign pass       = done && (mismatch_cnt == '0) && !timeout;

    always_comb begin
        load_acc = load_valid && load_ready && !clear;
        cmp_en   = (state == S_RUN) && retire_valid;
        cmp_hit  = (retire_pc == trace_pc[ptr_idx]) && (retire_result == trace_result[ptr_idx]);
        last_cmp = cmp_en && (ptr == count - 1'b1);
        // A final compare landing on the timeout cycle takes precedence.
        tmo_hit  = (state == S_RUN) && (cycle_cnt == TMO_LAST) && !last_cmp;
    end

    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (start && (count != '0 || load_acc)) state_nxt = S_RUN;
                S_RUN:   if (last_cmp || tmo_hit) state_nxt = S_DONE;
                S_DONE:  state_nxt = S_DONE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Trace storage is deliberately not reset; count==0 marks it empty.
    always_ff @(posedge clk) begin
        if (load_acc) begin
            trace_pc[count[AW-1:0]]     <= load_pc;
            trace_result[count[AW-1:0]] <= load_result;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count        <= '0;
            ptr          <= '0;
            fail_idx     <= '0;
            mismatch_cnt <= '0;
            cycle_cnt    <= '0;
            timeout      <= 1'b0;
        end else if (clear) begin
            count        <= '0;
            ptr          <= '0;
            fail_idx     <= '0;
            mismatch_cnt <= '0;
            cycle_cnt    <= '0;
            timeout      <= 1'b0;
        end else begin
            if (load_acc) begin
                count <= count + 1'b1;
            end
            if (state == S_IDLE && state_nxt == S_RUN) begin
                ptr          <= '0;
                fail_idx     <= '0;
                mismatch_cnt <= '0;
                cycle_cnt    <= '0;
                timeout      <= 1'b0;
            end
            if (state == S_RUN) begin
                if (cycle_cnt != '1) begin
                    cycle_cnt <= cycle_cnt + 32'd1;
                end
                if (cmp_en) begin
                    ptr <= ptr + 1'b1;
                    if (!cmp_hit) begin
                        if (mismatch_cnt != FULL) begin
                            mismatch_cnt <= mismatch_cnt + 1'b1;
                        end
                        if (mismatch_cnt == '0) begin
                            fail_idx <= ptr_idx;
                        end
                    end
                end
                if (tmo_hit) begin
                    timeout <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_retire_trace_checker.sv
// Scoreboard bench for retire_trace_checker: directed runs push expected verdicts, a monitor checks them when done rises.
module tb_retire_trace_checker;

    localparam int XLEN    = 32;
    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 20;
    localparam int AW      = $clog2(DEPTH);

    logic            clk = 1'b0;
    logic            rst;
    logic            clear;
    logic            load_valid;
    logic            load_ready;
    logic [XLEN-1:0] load_pc;
    logic [XLEN-1:0] load_result;
    logic            start;
    logic            retire_valid;
    logic [XLEN-1:0] retire_pc;
    logic [XLEN-1:0] retire_result;
    logic            busy;
    logic            done;
    logic            pass;
    logic            timeout;
    logic [AW-1:0]   fail_idx;
    logic [AW:0]     mismatch_cnt;
    logic [31:0]     cycle_cnt;

    retire_trace_checker #(.XLEN(XLEN), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .load_valid(load_valid), .load_ready(load_ready),
        .load_pc(load_pc), .load_result(load_result),
        .start(start),
        .retire_valid(retire_valid), .retire_pc(retire_pc), .retire_result(retire_result),
        .busy(busy), .done(done), .pass(pass), .timeout(timeout),
        .fail_idx(fail_idx), .mismatch_cnt(mismatch_cnt), .cycle_cnt(cycle_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic pass;
        logic tmo;
        int   mm;
        int   fidx;
        int   cyc;
    } exp_t;

    exp_t sbq[$];
    int   n_total = 0;
    int   n_pass  = 0;
    logic done_q  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Monitor: a rising done is the DUT presenting a verdict.
    always @(negedge clk) begin
        if (done && !done_q) begin
            if (sbq.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("pass",         {31'd0, pass},            {31'd0, e.pass});
                chk("timeout",      {31'd0, timeout},         {31'd0, e.tmo});
                chk("mismatch_cnt", 32'(mismatch_cnt),        32'(e.mm));
                chk("fail_idx",     32'(fail_idx),            32'(e.fidx));
                chk("cycle_cnt",    cycle_cnt,                32'(e.cyc));
            end
        end
        done_q = done;
    end

    function automatic logic [31:0] epc(input int i);
        return 32'h0000_1000 + 32'(i * 4);
    endfunction

    function automatic logic [31:0] eres(input int i);
        return 32'hA500_0000 + 32'(i * 17 + 3);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [31:0] pc, input logic [31:0] res);
        load_valid = 1'b1; load_pc = pc; load_result = res;
        tick();
        load_valid = 1'b0;
    endtask

    task automatic retire(input logic [31:0] pc, input logic [31:0] res);
        retire_valid = 1'b1; retire_pc = pc; retire_result = res;
        tick();
        retire_valid = 1'b0;
    endtask

    task automatic pulse_start;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_clear;
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic push_exp(input logic p, input logic t, input int mm, input int fi, input int cy);
        exp_t e;
        e.pass = p; e.tmo = t; e.mm = mm; e.fidx = fi; e.cyc = cy;
        sbq.push_back(e);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},         {31'd0, busy},       32'd0);
        chk({tag, "_done"},         {31'd0, done},       32'd0);
        chk({tag, "_pass"},         {31'd0, pass},       32'd0);
        chk({tag, "_timeout"},      {31'd0, timeout},    32'd0);
        chk({tag, "_mismatch_cnt"}, 32'(mismatch_cnt),   32'd0);
        chk({tag, "_fail_idx"},     32'(fail_idx),       32'd0);
        chk({tag, "_cycle_cnt"},    cycle_cnt,           32'd0);
        chk({tag, "_load_ready"},   {31'd0, load_ready}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; clear = 1'b0; load_valid = 1'b0; load_pc = '0; load_result = '0;
        start = 1'b0; retire_valid = 1'b0; retire_pc = '0; retire_result = '0;
        repeat (2) tick();
        chk_all_zero("reset");
        rst = 1'b1;
        tick();
        chk("post_reset_load_ready", {31'd0, load_ready}, 32'd1);

        // 1: three matching retirements
        for (int i = 0; i < 3; i++) load(epc(i), eres(i));
        push_exp(1'b1, 1'b0, 0, 0, 3);
        pulse_start();
        chk("t1_busy", {31'd0, busy}, 32'd1);
        chk("t1_load_ready_run", {31'd0, load_ready}, 32'd0);
        for (int i = 0; i < 3; i++) retire(epc(i), eres(i));
        tick();
        pulse_clear();
        chk("t1_clear_done", {31'd0, done}, 32'd0);

        // 2: entries 1 and 3 carry result+1
        for (int i = 0; i < 4; i++) load(epc(i), eres(i));
        push_exp(1'b0, 1'b0, 2, 1, 4);
        pulse_start();
        for (int i = 0; i < 4; i++) retire(epc(i), eres(i) + ((i % 2 == 1) ? 32'd1 : 32'd0));
        tick();
        pulse_clear();

        // 3: timeout after one retirement
        for (int i = 0; i < 2; i++) load(epc(i), eres(i));
        push_exp(1'b0, 1'b1, 0, 0, TIMEOUT);
        pulse_start();
        retire(epc(0), eres(0));
        repeat (TIMEOUT - 2) tick();
        chk("t3_busy_before_tmo", {31'd0, busy}, 32'd1);
        tick();
        chk("t3_busy_after_tmo", {31'd0, busy}, 32'd0);
        pulse_clear();

        // 4: fill the trace; a further write must be dropped
        for (int i = 0; i < DEPTH; i++) begin
            chk("t4_load_ready_open", {31'd0, load_ready}, 32'd1);
            load(epc(i), eres(i));
        end
        chk("t4_load_ready_full", {31'd0, load_ready}, 32'd0);
        load(32'hDEAD_BEEF, 32'hBAD0_BAD0);
        chk("t4_load_ready_still_full", {31'd0, load_ready}, 32'd0);
        push_exp(1'b1, 1'b0, 0, 0, DEPTH);
        pulse_start();
        for (int i = 0; i < DEPTH; i++) retire(epc(i), eres(i));
        tick();
        chk("t4_done_after_depth", {31'd0, done}, 32'd1);
        pulse_clear();

        // 5a: start with empty trace is ignored
        pulse_start();
        chk("t5_busy_empty_start", {31'd0, busy}, 32'd0);
        tick();
        chk("t5_busy_empty_later", {31'd0, busy}, 32'd0);
        chk("t5_done_empty", {31'd0, done}, 32'd0);

        // 5b: last compare on the timeout cycle wins
        for (int i = 0; i < 2; i++) load(epc(i), eres(i));
        push_exp(1'b1, 1'b0, 0, 0, TIMEOUT);
        pulse_start();
        retire(epc(0), eres(0));
        repeat (TIMEOUT - 2) tick();
        retire(epc(1), eres(1));
        tick();
        pulse_clear();

        // 6: asynchronous reset mid-run, then a fresh one-entry run
        for (int i = 0; i < 2; i++) load(epc(i), eres(i));
        pulse_start();
        retire(epc(0), eres(0) ^ 32'h1);
        chk("t6_busy_pre_reset", {31'd0, busy}, 32'd1);
        chk("t6_mm_pre_reset", 32'(mismatch_cnt), 32'd1);
        rst = 1'b0;
        #2;
        chk_all_zero("t6_async");
        tick();
        rst = 1'b1;
        tick();
        chk("t6_load_ready_after", {31'd0, load_ready}, 32'd1);
        pulse_start();
        chk("t6_busy_no_trace", {31'd0, busy}, 32'd0);
        load(epc(5), eres(5));
        push_exp(1'b1, 1'b0, 0, 0, 1);
        pulse_start();
        retire(epc(5), eres(5));
        tick();

        for (int i = 0; i < 50 && sbq.size() != 0; i++) tick();
        chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
